// File: rtl/sim_jtag_tap.sv
// JTAG TAP responder running in the system clock domain: oversamples the host pins and
// implements the IEEE 1149.1 controller with IR, IDCODE, BYPASS and one USER data register.
module sim_jtag_tap #(
  parameter int unsigned         IR_WIDTH     = 5,
  parameter int unsigned         DR_WIDTH     = 32,
  parameter logic [31:0]         IDCODE_VALUE = 32'h10E31913,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(5'h01),
  parameter logic [IR_WIDTH-1:0] USER_INSTR   = IR_WIDTH'(5'h11)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jtag_TCK,
  input  logic                jtag_TMS,
  input  logic                jtag_TDI,
  input  logic                jtag_TRSTn,
  output logic                jtag_TDO_data,
  output logic                jtag_TDO_driven,
  input  logic [DR_WIDTH-1:0] dr_capture_data,
  output logic                dr_capture,
  output logic [DR_WIDTH-1:0] dr_update_data,
  output logic                dr_update,
  output logic [3:0]          tap_state
);

  localparam int unsigned ID_WIDTH = 32;

  typedef enum logic [3:0] {
    ST_TLR     = 4'hF,
    ST_RTI     = 4'hC,
    ST_SEL_DR  = 4'h7,
    ST_CAP_DR  = 4'h6,
    ST_SH_DR   = 4'h2,
    ST_EX1_DR  = 4'h1,
    ST_PAUSE_DR= 4'h3,
    ST_EX2_DR  = 4'h0,
    ST_UPD_DR  = 4'h5,
    ST_SEL_IR  = 4'h4,
    ST_CAP_IR  = 4'hE,
    ST_SH_IR   = 4'hA,
    ST_EX1_IR  = 4'h9,
    ST_PAUSE_IR= 4'hB,
    ST_EX2_IR  = 4'h8,
    ST_UPD_IR  = 4'hD
  } state_e;

  logic tck_s1, tck_s2, tck_s3;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic trstn_s1, trstn_s2;
  logic rise, fall, trst;

  state_e state_q, state_d;

  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [ID_WIDTH-1:0] id_shift;
  logic [DR_WIDTH-1:0] user_shift;
  logic                bypass;
  logic                id_sel, user_sel;
  logic                dr_lsb;

  // Two-flop synchronizers; the third TCK flop provides edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      tck_s1   <= 1'b0;
      tck_s2   <= 1'b0;
      tck_s3   <= 1'b0;
      tms_s1   <= 1'b0;
      tms_s2   <= 1'b0;
      tdi_s1   <= 1'b0;
      tdi_s2   <= 1'b0;
      trstn_s1 <= 1'b1;
      trstn_s2 <= 1'b1;
    end else begin
      tck_s1   <= jtag_TCK;
      tck_s2   <= tck_s1;
      tck_s3   <= tck_s2;
      tms_s1   <= jtag_TMS;
      tms_s2   <= tms_s1;
      tdi_s1   <= jtag_TDI;
      tdi_s2   <= tdi_s1;
      trstn_s1 <= jtag_TRSTn;
      trstn_s2 <= trstn_s1;
    end
  end

  assign rise = tck_s2 & ~tck_s3;
  assign fall = ~tck_s2 & tck_s3;
  assign trst = ~trstn_s2;

  always_ff @(posedge clock) begin
    if (reset || trst) state_q <= ST_TLR;
    else               state_q <= state_d;
  end

  // IEEE 1149.1 transitions, advanced once per TCK rise
  always_comb begin
    state_d = state_q;
    if (rise) begin
      case (state_q)
        ST_TLR:      state_d = tms_s2 ? ST_TLR    : ST_RTI;
        ST_RTI:      state_d = tms_s2 ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR:   state_d = tms_s2 ? ST_SEL_IR : ST_CAP_DR;
        ST_CAP_DR:   state_d = tms_s2 ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:    state_d = tms_s2 ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR:   state_d = tms_s2 ? ST_UPD_DR : ST_PAUSE_DR;
        ST_PAUSE_DR: state_d = tms_s2 ? ST_EX2_DR : ST_PAUSE_DR;
        ST_EX2_DR:   state_d = tms_s2 ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR:   state_d = tms_s2 ? ST_SEL_DR : ST_RTI;
        ST_SEL_IR:   state_d = tms_s2 ? ST_TLR    : ST_CAP_IR;
        ST_CAP_IR:   state_d = tms_s2 ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:    state_d = tms_s2 ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR:   state_d = tms_s2 ? ST_UPD_IR : ST_PAUSE_IR;
        ST_PAUSE_IR: state_d = tms_s2 ? ST_EX2_IR : ST_PAUSE_IR;
        ST_EX2_IR:   state_d = tms_s2 ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR:   state_d = tms_s2 ? ST_SEL_DR : ST_RTI;
        default:     state_d = ST_TLR;
      endcase
    end
  end

  assign tap_state = state_q;
  assign id_sel    = (ir == IDCODE_INSTR);
  assign user_sel  = (ir == USER_INSTR);

  always_comb begin
    dr_lsb = bypass;
    if (id_sel)        dr_lsb = id_shift[0];
    else if (user_sel) dr_lsb = user_shift[0];
  end

  // Register actions keyed to the state held before each rise
  always_ff @(posedge clock) begin
    dr_capture <= 1'b0;
    dr_update  <= 1'b0;
    if (reset) begin
      ir             <= IDCODE_INSTR;
      ir_shift       <= '0;
      id_shift       <= '0;
      user_shift     <= '0;
      bypass         <= 1'b0;
      dr_update_data <= '0;
    end else if (trst) begin
      ir <= IDCODE_INSTR;
    end else if (rise) begin
      case (state_q)
        ST_TLR:    ir <= IDCODE_INSTR;
        ST_CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
        ST_SH_IR:  ir_shift <= {tdi_s2, ir_shift[IR_WIDTH-1:1]};
        ST_UPD_IR: ir <= ir_shift;
        ST_CAP_DR: begin
          if (id_sel) begin
            id_shift <= IDCODE_VALUE;
          end else if (user_sel) begin
            user_shift <= dr_capture_data;
            dr_capture <= 1'b1;
          end else begin
            bypass <= 1'b0;
          end
        end
        ST_SH_DR: begin
          if (id_sel)        id_shift   <= {tdi_s2, id_shift[ID_WIDTH-1:1]};
          else if (user_sel) user_shift <= (user_shift >> 1) | (DR_WIDTH'(tdi_s2) << (DR_WIDTH - 1));
          else               bypass     <= tdi_s2;
        end
        ST_UPD_DR: begin
          if (user_sel) begin
            dr_update_data <= user_shift;
            dr_update      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // TDO launched on the falling edge; data holds while not driven
  always_ff @(posedge clock) begin
    if (reset) begin
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else if (trst) begin
      jtag_TDO_driven <= 1'b0;
    end else if (fall) begin
      jtag_TDO_driven <= (state_q == ST_SH_DR) || (state_q == ST_SH_IR);
      if (state_q == ST_SH_IR)      jtag_TDO_data <= ir_shift[0];
      else if (state_q == ST_SH_DR) jtag_TDO_data <= dr_lsb;
    end
  end

endmodule

// File: tb/tb_sim_jtag_tap.sv
// Scoreboard bench for sim_jtag_tap: scan tasks queue expected TDO bits, capture and update
// events from a stream model; monitors pop and compare when the DUT presents them.
module tb_sim_jtag_tap;

  localparam logic [31:0] IDCODE     = 32'h10E31913;
  localparam logic [4:0]  ID_INSTR   = 5'h01;
  localparam logic [4:0]  USER_INSTR = 5'h11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tck_pin = 1'b0;
  logic        tms = 1'b0;
  logic        tdi = 1'b0;
  logic        trstn = 1'b1;
  logic        jtag_TDO_data;
  logic        jtag_TDO_driven;
  logic [31:0] dr_capture_data = '0;
  logic        dr_capture;
  logic [31:0] dr_update_data;
  logic        dr_update;
  logic [3:0]  tap_state;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0]  model_ir = ID_INSTR;
  bit          tdo_q[$];
  logic [31:0] upd_q[$];
  logic [3:0]  cap_q[$];

  sim_jtag_tap dut (
    .clock           (clock),
    .reset           (reset),
    .jtag_TCK        (tck_pin),
    .jtag_TMS        (tms),
    .jtag_TDI        (tdi),
    .jtag_TRSTn      (trstn),
    .jtag_TDO_data   (jtag_TDO_data),
    .jtag_TDO_driven (jtag_TDO_driven),
    .dr_capture_data (dr_capture_data),
    .dr_capture      (dr_capture),
    .dr_update_data  (dr_update_data),
    .dr_update       (dr_update),
    .tap_state       (tap_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT presented %0h with nothing expected", name, act);
  endtask

  // Host samples TDO on each TCK rise while the DUT drives it
  always @(posedge tck_pin) begin
    if (jtag_TDO_driven) begin
      if (tdo_q.size() == 0) unexpected("tdo_extra", 64'(jtag_TDO_data));
      else check("tdo_bit", 64'(jtag_TDO_data), 64'(tdo_q.pop_front()));
    end
  end

  always @(negedge clock) begin
    if (dr_update) begin
      if (upd_q.size() == 0) unexpected("dr_update_extra", 64'(dr_update_data));
      else check("dr_update_data", 64'(dr_update_data), 64'(upd_q.pop_front()));
    end
    if (dr_capture) begin
      if (cap_q.size() == 0) unexpected("dr_capture_extra", 64'(tap_state));
      else check("dr_capture_state", 64'(tap_state), 64'(cap_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, run incomplete");
    $fatal(1, "watchdog");
  end

  // One TCK period with setup and hold well inside the oversampling limits
  task automatic tck(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    repeat (4) @(negedge clock);
    tck_pin = 1'b1;
    repeat (5) @(negedge clock);
    tck_pin = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  // Shift stream view: captured value first, then TDI bits; outputs are the first n bits,
  // the register afterwards is the next w bits.
  function automatic void prep_dr(input logic [63:0] din, input int n, input logic [31:0] cap,
                                  input bit do_upd);
    int           w;
    logic [31:0]  cval;
    logic [127:0] s;
    w    = 1;
    cval = '0;
    if (model_ir == ID_INSTR) begin
      w    = 32;
      cval = IDCODE;
    end else if (model_ir == USER_INSTR) begin
      w    = 32;
      cval = cap;
      cap_q.push_back(4'h2);
    end
    s = 128'(cval) | (128'(din) << w);
    for (int i = 0; i < n; i++) tdo_q.push_back(s[i]);
    if (do_upd && model_ir == USER_INSTR) upd_q.push_back(s[n +: 32]);
  endfunction

  task automatic ir_scan(input logic [4:0] v);
    logic [15:0] s;
    s = 16'(2'b01) | (16'(v) << 5);
    for (int i = 0; i < 5; i++) tdo_q.push_back(s[i]);
    tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    check("shir_state", 64'(tap_state), 64'hA);
    for (int i = 0; i < 5; i++) tck(i == 4, v[i]);
    tck(1'b1, 1'b0); tck(1'b0, 1'b0);
    check("ir_rti_state", 64'(tap_state), 64'hC);
    model_ir = v;
  endtask

  task automatic dr_scan(input logic [63:0] din, input int n, input logic [31:0] cap);
    dr_capture_data = cap;
    prep_dr(din, n, cap, 1'b1);
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    check("shdr_state", 64'(tap_state), 64'h2);
    for (int i = 0; i < n; i++) tck(i == n - 1, din[i]);
    check("ex1dr_state", 64'(tap_state), 64'h1);
    check("ex1dr_driven", 64'(jtag_TDO_driven), 64'h0);
    tck(1'b1, 1'b0); tck(1'b0, 1'b0);
    check("dr_rti_state", 64'(tap_state), 64'hC);
  endtask

  initial begin
    logic [63:0] din;
    logic [31:0] cap;
    logic [4:0]  op;
    int          n;

    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_state", 64'(tap_state), 64'hF);
    check("rst_tdo_data", 64'(jtag_TDO_data), 64'h0);
    check("rst_tdo_driven", 64'(jtag_TDO_driven), 64'h0);
    check("rst_update_data", 64'(dr_update_data), 64'h0);
    check("rst_pulses", 64'({dr_capture, dr_update}), 64'h0);

    tck(1'b0, 1'b0);
    check("first_rti_state", 64'(tap_state), 64'hC);
    check("first_rti_driven", 64'(jtag_TDO_driven), 64'h0);

    dr_scan(64'h0, 32, 32'h0);                     // IDCODE read
    ir_scan(5'h1F);
    dr_scan(64'b1101, 4, 32'h0);                   // bypass: TDO 0,1,0,1
    ir_scan(USER_INSTR);
    dr_scan(64'h12345678, 32, 32'hA5A50F0F);

    // Five TMS=1 rises from Shift-DR with USER selected; the walk passes Update-DR
    cap = $urandom;
    din = {$urandom, $urandom};
    dr_capture_data = cap;
    prep_dr(din, 4, cap, 1'b1);
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tck(1'b0, din[i]);
    for (int i = 0; i < 5; i++) tck(1'b1, (i == 0) ? din[3] : 1'b0);
    check("tms_abort_state", 64'(tap_state), 64'hF);
    check("tms_abort_driven", 64'(jtag_TDO_driven), 64'h0);
    tck(1'b0, 1'b0);
    model_ir = ID_INSTR;
    check("tms_abort_rti", 64'(tap_state), 64'hC);
    dr_scan(64'h0, 32, 32'h0);

    // TRSTn pulled low in the middle of Shift-IR
    tdo_q.push_back(1'b1);
    tdo_q.push_back(1'b0);
    tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    tck(1'b0, 1'b1); tck(1'b0, 1'b1);
    trstn = 1'b0;
    repeat (3) @(negedge clock);
    check("trst_state", 64'(tap_state), 64'hF);
    check("trst_driven", 64'(jtag_TDO_driven), 64'h0);
    trstn = 1'b1;
    repeat (4) @(negedge clock);
    tck(1'b0, 1'b0);
    model_ir = ID_INSTR;
    check("trst_rti", 64'(tap_state), 64'hC);
    dr_scan(64'h0, 32, 32'h0);

    // Reset in the middle of a USER Shift-DR discards the partial scan
    ir_scan(USER_INSTR);
    cap = $urandom;
    din = {$urandom, $urandom};
    dr_capture_data = cap;
    prep_dr(din, 2, cap, 1'b0);
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    tck(1'b0, din[0]); tck(1'b0, din[1]);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_state", 64'(tap_state), 64'hF);
    check("midrst_tdo", 64'({jtag_TDO_driven, jtag_TDO_data}), 64'h0);
    check("midrst_update_data", 64'(dr_update_data), 64'h0);
    check("midrst_pulses", 64'({dr_capture, dr_update}), 64'h0);
    reset = 1'b0;
    model_ir = ID_INSTR;
    repeat (2) @(negedge clock);
    tck(1'b0, 1'b0);
    check("midrst_rti", 64'(tap_state), 64'hC);
    dr_scan(64'h0, 32, 32'h0);

    // Randomized IR/DR scans
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0:       op = ID_INSTR;
        1:       op = USER_INSTR;
        2:       op = 5'h1F;
        default: op = 5'($urandom);
      endcase
      ir_scan(op);
      n   = int'($urandom_range(1, 40));
      din = {$urandom, $urandom};
      cap = $urandom;
      dr_scan(din, n, cap);
    end

    repeat (4) @(negedge clock);
    check("tdo_queue_left", 64'(tdo_q.size()), 64'h0);
    check("update_queue_left", 64'(upd_q.size()), 64'h0);
    check("capture_queue_left", 64'(cap_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
